// File: rtl/sd_dat_rx_crc.sv
// sd_dat_rx_crc: receive engine for one SD data block on a 1/4/8-lane DAT bus.
// Waits for the start bit, assembles data bytes MSB first, runs a serial
// CRC16-CCITT per lane, then captures and checks the received per-lane CRC and
// the end bit. Reports done, per-lane CRC errors, framing error and timeout.
module sd_dat_rx_crc #(
  parameter int unsigned       LANES   = 4,
  parameter int unsigned       LEN_W   = 10,
  parameter int unsigned       TMO_W   = 16,
  parameter logic [TMO_W-1:0]  TMO_CYC = 16'd65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [LEN_W-1:0]     i_blk_len,
  input  logic                 i_dat_valid,
  input  logic [LANES-1:0]     i_dat,
  output logic                 o_busy,
  output logic                 o_byte_valid,
  output logic [7:0]           o_byte,
  output logic                 o_done,
  output logic [LANES-1:0]     o_crc_err,
  output logic                 o_frm_err,
  output logic                 o_timeout,
  output logic [16*LANES-1:0]  o_crc
);

  // Sample counter must hold 2^LEN_W*8 - 1 (1024 bytes on one lane).
  localparam int unsigned CNT_W = LEN_W + 3;
  // log2(LANES): samples per block = bytes*8 >> LSH.
  localparam int unsigned LSH   = (LANES == 1) ? 0 : ((LANES == 4) ? 2 : 3);
  // Low counter bits that are all ones on the sample completing a byte.
  localparam logic [2:0]  SPB_MASK = (LANES == 1) ? 3'd7 : ((LANES == 4) ? 3'd1 : 3'd0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_CYC - 1'b1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_DATA  = 3'd2,
    S_CRC   = 3'd3,
    S_END   = 3'd4
  } state_t;

  // One serial CRC16-CCITT step (x^16 + x^12 + x^5 + 1), MSB first.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic d);
    logic fb;
    fb = crc[15] ^ d;
    return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  state_t               state_q, state_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [7:0]           sh_q, sh_d;
  logic [16*LANES-1:0]  crc_q, crc_d;
  logic [16*LANES-1:0]  rx_q, rx_d;
  logic                 busy_q, busy_d;
  logic                 bv_q, bv_d;
  logic [7:0]           byte_q, byte_d;
  logic                 done_q, done_d;
  logic [LANES-1:0]     cerr_q, cerr_d;
  logic                 frm_q, frm_d;
  logic                 tmof_q, tmof_d;
  logic [16*LANES-1:0]  ocrc_q, ocrc_d;

  logic [LEN_W:0]       len_full_s;
  logic [CNT_W:0]       data_samples_s;
  logic [CNT_W-1:0]     data_last_s;
  logic [7:0]           sh_next_s;

  // A zero length means 2^LEN_W bytes; last DATA sample index follows from it.
  assign len_full_s     = {(len_q == {LEN_W{1'b0}}), len_q};
  assign data_samples_s = {len_full_s, 3'b000} >> LSH;
  assign data_last_s    = CNT_W'(data_samples_s - 1'b1);
  // Byte shifter: older lanes' bits move toward the MSB, new sample enters low.
  assign sh_next_s      = (sh_q << LANES) | 8'(i_dat);

  // State register and all datapath/output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= {LEN_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      tmo_q   <= {TMO_W{1'b0}};
      sh_q    <= 8'h00;
      crc_q   <= {(16*LANES){1'b0}};
      rx_q    <= {(16*LANES){1'b0}};
      busy_q  <= 1'b0;
      bv_q    <= 1'b0;
      byte_q  <= 8'h00;
      done_q  <= 1'b0;
      cerr_q  <= {LANES{1'b0}};
      frm_q   <= 1'b0;
      tmof_q  <= 1'b0;
      ocrc_q  <= {(16*LANES){1'b0}};
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      sh_q    <= sh_d;
      crc_q   <= crc_d;
      rx_q    <= rx_d;
      busy_q  <= busy_d;
      bv_q    <= bv_d;
      byte_q  <= byte_d;
      done_q  <= done_d;
      cerr_q  <= cerr_d;
      frm_q   <= frm_d;
      tmof_q  <= tmof_d;
      ocrc_q  <= ocrc_d;
    end
  end

  // Next-state and next-output logic; stalls (no valid sample) hold everything.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    sh_d    = sh_q;
    crc_d   = crc_q;
    rx_d    = rx_q;
    busy_d  = busy_q;
    bv_d    = 1'b0;
    byte_d  = byte_q;
    done_d  = 1'b0;
    cerr_d  = cerr_q;
    frm_d   = frm_q;
    tmof_d  = tmof_q;
    ocrc_d  = ocrc_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          len_d   = i_blk_len;
          cnt_d   = {CNT_W{1'b0}};
          tmo_d   = {TMO_W{1'b0}};
          crc_d   = {(16*LANES){1'b0}};
          rx_d    = {(16*LANES){1'b0}};
          cerr_d  = {LANES{1'b0}};
          frm_d   = 1'b0;
          tmof_d  = 1'b0;
          ocrc_d  = {(16*LANES){1'b0}};
          busy_d  = 1'b1;
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        tmo_d = tmo_q + 1'b1;
        if (i_dat_valid && (i_dat == {LANES{1'b0}})) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_DATA;
        end else if (tmo_q == TMO_LAST) begin
          tmof_d  = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DATA: begin
        if (i_dat_valid) begin
          for (int i = 0; i < LANES; i++) begin
            crc_d[16*i +: 16] = crc16_step(crc_q[16*i +: 16], i_dat[i]);
          end
          sh_d = sh_next_s;
          if ((cnt_q[2:0] & SPB_MASK) == SPB_MASK) begin
            bv_d   = 1'b1;
            byte_d = sh_next_s;
          end else begin
            bv_d   = 1'b0;
          end
          if (cnt_q == data_last_s) begin
            cnt_d   = {CNT_W{1'b0}};
            state_d = S_CRC;
          end else begin
            cnt_d   = cnt_q + 1'b1;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_CRC: begin
        if (i_dat_valid) begin
          for (int i = 0; i < LANES; i++) begin
            rx_d[16*i +: 16] = {rx_q[16*i +: 15], i_dat[i]};
          end
          if (cnt_q[3:0] == 4'd15) begin
            cnt_d   = {CNT_W{1'b0}};
            state_d = S_END;
          end else begin
            cnt_d   = cnt_q + 1'b1;
          end
        end else begin
          state_d = S_CRC;
        end
      end
      S_END: begin
        if (i_dat_valid) begin
          frm_d = (i_dat != {LANES{1'b1}});
          for (int i = 0; i < LANES; i++) begin
            cerr_d[i] = (rx_q[16*i +: 16] != crc_q[16*i +: 16]);
          end
          ocrc_d  = crc_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_END;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_busy       = busy_q;
  assign o_byte_valid = bv_q;
  assign o_byte       = byte_q;
  assign o_done       = done_q;
  assign o_crc_err    = cerr_q;
  assign o_frm_err    = frm_q;
  assign o_timeout    = tmof_q;
  assign o_crc        = ocrc_q;

endmodule
